// File: rtl/hilo_div_unit_if.sv
// Datapath-facing bundle of the HI/LO divider: decode flags, operands, stall and read-back.
// The datapath drives through master; the divider attaches as slave.
interface hilo_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             isDiv;
    logic             ismfhi;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic [WIDTH-1:0] mfData;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output isDiv, ismfhi, dividend, divisor,
        input  busy, mfData, hi, lo
    );

    modport slave (
        input  isDiv, ismfhi, dividend, divisor,
        output busy, mfData, hi, lo
    );
endinterface

// File: rtl/hilo_div_unit.sv
// Multi-cycle signed restoring divider owning the MIPS HI/LO pair.
// Stalls the PC while dividing; quotient goes to LO and remainder to HI.
module hilo_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clock,
    input logic             reset,
    hilo_div_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e           stateQ, stateD;
    logic [WIDTH-1:0] remQ, remD;
    logic [WIDTH-1:0] quoQ, quoD;
    logic [WIDTH-1:0] dvsrQ, dvsrD;
    logic [CW-1:0]    countQ, countD;
    logic             qNegQ, qNegD;
    logic             rNegQ, rNegD;
    logic             dzQ, dzD;
    logic [WIDTH-1:0] hiQ, hiD;
    logic [WIDTH-1:0] loQ, loD;

    logic [WIDTH-1:0] absDividend, absDivisor;
    logic [WIDTH:0]   shifted, trial;

    // Most negative operand wraps to itself, which is still its unsigned magnitude.
    assign absDividend = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign absDivisor  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    assign shifted = {remQ, quoQ[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvsrQ};

    always_comb begin
        stateD = stateQ;
        remD   = remQ;
        quoD   = quoQ;
        dvsrD  = dvsrQ;
        countD = countQ;
        qNegD  = qNegQ;
        rNegD  = rNegQ;
        dzD    = dzQ;
        hiD    = hiQ;
        loD    = loQ;

        unique case (stateQ)
            StIdle: begin
                if (bus.isDiv) begin
                    quoD   = absDividend;
                    dvsrD  = absDivisor;
                    qNegD  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    rNegD  = bus.dividend[WIDTH-1];
                    remD   = '0;
                    countD = CW'(WIDTH);
                    dzD    = (bus.divisor == '0);
                    stateD = (bus.divisor == '0) ? StFix : StCalc;
                end
            end
            StCalc: begin
                if (!trial[WIDTH]) begin
                    remD = trial[WIDTH-1:0];
                    quoD = {quoQ[WIDTH-2:0], 1'b1};
                end else begin
                    remD = shifted[WIDTH-1:0];
                    quoD = {quoQ[WIDTH-2:0], 1'b0};
                end
                countD = countQ - 1'b1;
                if (countQ == CW'(1)) begin
                    stateD = StFix;
                end
            end
            StFix: begin
                // On divide-by-zero quo still holds |dividend|, so re-signing restores it.
                if (dzQ) begin
                    loD = '1;
                    hiD = rNegQ ? -quoQ : quoQ;
                end else begin
                    loD = qNegQ ? -quoQ : quoQ;
                    hiD = rNegQ ? -remQ : remQ;
                end
                stateD = StDone;
            end
            StDone: begin
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ <= StIdle;
            remQ   <= '0;
            quoQ   <= '0;
            dvsrQ  <= '0;
            countQ <= '0;
            qNegQ  <= 1'b0;
            rNegQ  <= 1'b0;
            dzQ    <= 1'b0;
            hiQ    <= '0;
            loQ    <= '0;
        end else begin
            stateQ <= stateD;
            remQ   <= remD;
            quoQ   <= quoD;
            dvsrQ  <= dvsrD;
            countQ <= countD;
            qNegQ  <= qNegD;
            rNegQ  <= rNegD;
            dzQ    <= dzD;
            hiQ    <= hiD;
            loQ    <= loD;
        end
    end

    assign bus.busy   = ((stateQ == StIdle) && bus.isDiv) || (stateQ == StCalc)
                        || (stateQ == StFix);
    assign bus.mfData = bus.ismfhi ? hiQ : loQ;
    assign bus.hi     = hiQ;
    assign bus.lo     = loQ;
endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: latency, signed results, divide-by-zero, overflow,
// reset abort, back-to-back divs and operand stability.
module tb_hilo_div_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nChecks = 0;
    int   nPass = 0;
    int   n;
    int   n2;

    hilo_div_unit_if #(.WIDTH(32)) bus ();

    hilo_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got === want) nPass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    endtask

    // Issues a div and counts busy cycles; returns during the DONE cycle.
    task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input int changeAt,
                          input bit holdAfter, output int cycles);
        @(negedge clock);
        bus.isDiv    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        #1;
        cycles = 0;
        while (bus.busy && cycles < 200) begin
            cycles++;
            @(negedge clock);
            #1;
            if (cycles == changeAt) bus.divisor = 32'd1;
        end
        if (!holdAfter) bus.isDiv = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic [31:0] wantLo,
                               input logic [31:0] wantHi);
        @(negedge clock);
        #1;
        check({tag, " lo"}, bus.lo, wantLo);
        check({tag, " hi"}, bus.hi, wantHi);
    endtask

    initial begin
        bus.isDiv    = 1'b0;
        bus.ismfhi   = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset busy idle", {31'd0, bus.busy}, 32'd0);
        bus.isDiv = 1'b1;
        #1;
        check("reset busy follows isDiv", {31'd0, bus.busy}, 32'd1);
        bus.isDiv = 1'b0;

        runDiv(32'd100, 32'd7, -1, 1'b0, n);
        check("100/7 busy cycles", n, 32'd34);
        checkResult("100/7", 32'd14, 32'd2);
        bus.ismfhi = 1'b1;
        #1;
        check("mfhi", bus.mfData, 32'd2);
        bus.ismfhi = 1'b0;
        #1;
        check("mflo", bus.mfData, 32'd14);

        runDiv(-32'sd7, 32'd2, -1, 1'b0, n);
        checkResult("-7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        runDiv(32'd7, -32'sd2, -1, 1'b0, n);
        checkResult("7/-2", 32'hFFFF_FFFD, 32'd1);

        runDiv(32'd5, 32'd0, -1, 1'b0, n);
        check("5/0 busy cycles", n, 32'd2);
        checkResult("5/0", 32'hFFFF_FFFF, 32'd5);

        runDiv(32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, n);
        check("ovf busy cycles", n, 32'd34);
        checkResult("ovf", 32'h8000_0000, 32'd0);

        runDiv(32'd100, 32'd7, 5, 1'b0, n);
        checkResult("operand change", 32'd14, 32'd2);

        // Reset in CALC cycle 10 with committed HI/LO = 2/14.
        @(negedge clock);
        bus.isDiv    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        repeat (10) @(negedge clock);
        #1;
        check("calc busy", {31'd0, bus.busy}, 32'd1);
        check("calc lo unchanged", bus.mfData, 32'd14);
        reset      = 1'b1;
        bus.isDiv  = 1'b0;
        @(negedge clock);
        #1;
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        runDiv(32'd5, 32'd0, -1, 1'b0, n);
        check("post-abort 5/0 busy", n, 32'd2);
        checkResult("post-abort 5/0", 32'hFFFF_FFFF, 32'd5);

        // Back-to-back: isDiv stays high through DONE of the first.
        runDiv(32'd9, 32'd4, -1, 1'b1, n);
        check("b2b first busy", n, 32'd34);
        check("b2b done not busy", {31'd0, bus.busy}, 32'd0);
        check("b2b first lo", bus.lo, 32'd2);
        check("b2b first hi", bus.hi, 32'd1);
        runDiv(32'd20, 32'd6, -1, 1'b0, n2);
        check("b2b second busy", n2, 32'd34);
        check("b2b total busy", n + n2, 32'd68);
        checkResult("b2b second", 32'd3, 32'd2);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
